// File: rtl/frac_clk_en_gen_if.sv
// frac_clk_en_gen_if
//   Ratio configuration port for frac_clk_en_gen. A ratio NUM/DEN moves
//   across on any clock edge where cfg_valid and cfg_ready are both high.
//   Signals:
//     cfg_valid  master -> slave  new ratio offered
//     cfg_ready  slave  -> master block can accept a ratio
//     cfg_num    master -> slave  numerator   (ACC_W bits)
//     cfg_den    master -> slave  denominator (ACC_W bits)
interface frac_clk_en_gen_if #(
  parameter int ACC_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;

  modport master (output cfg_valid, output cfg_num, output cfg_den, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_num, input cfg_den, output cfg_ready);
endinterface

// File: rtl/frac_clk_en_gen.sv
// frac_clk_en_gen
//   Fractional clock-enable generator. Emits registered one-cycle clk_en
//   pulses at an average rate of NUM/DEN of clk_in using a phase accumulator.
//   The ratio is reprogrammable at runtime; a ratio accepted while running is
//   held pending and only applied on a pulse edge, so no pulse is ever
//   truncated or doubled by a ratio change.
//   Optional feature macro: FRAC_CLK_EN_CNT_EN adds the CNT_W parameter and
//   the pulse_cnt output (pulses issued since entering RUN).
//   Ports:
//     clk_in     single clock
//     rst        synchronous active-high reset
//     en         run request; low = idle, no pulses
//     cfg        ratio handshake (frac_clk_en_gen_if.slave)
//     clk_en     registered one-cycle enable strobe
//     cfg_err    one-cycle pulse: accepted ratio was invalid and discarded
//     pulse_cnt  clk_en pulses since entering RUN (FRAC_CLK_EN_CNT_EN only)
module frac_clk_en_gen #(
  parameter int ACC_W       = 16,
  parameter int DEFAULT_NUM = 1,
  parameter int DEFAULT_DEN = 4
`ifdef FRAC_CLK_EN_CNT_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  frac_clk_en_gen_if.slave  cfg,
  output logic              clk_en,
  output logic              cfg_err
`ifdef FRAC_CLK_EN_CNT_EN
  , output logic [CNT_W-1:0] pulse_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_reg, state_next;
  // acc stays strictly below den, so ACC_W bits hold it; the sum carries
  // one extra bit so acc + num can never wrap.
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] num_reg, num_next;
  logic [ACC_W-1:0] den_reg, den_next;
  logic [ACC_W-1:0] pend_num_reg, pend_num_next;
  logic [ACC_W-1:0] pend_den_reg, pend_den_next;
  logic             clk_en_reg, clk_en_next;
  logic             cfg_err_reg, cfg_err_next;

  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             hit;
  logic             num_zero;
  logic             accept;
  logic             cfg_ok;
  logic             take;

  assign sum      = {1'b0, acc_reg} + {1'b0, num_reg};
  assign diff     = sum - {1'b0, den_reg};
  assign hit      = (sum >= {1'b0, den_reg});
  assign num_zero = (num_reg == '0);
  assign accept   = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok   = (cfg.cfg_den != '0) && (cfg.cfg_num <= cfg.cfg_den);
  assign take     = accept && cfg_ok;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
               else if (take) state_next = PEND;
      PEND:    if (!en) state_next = IDLE;
               else if (hit || num_zero) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cfg.cfg_ready = (state_reg != PEND);
    acc_next      = acc_reg;
    num_next      = num_reg;
    den_next      = den_reg;
    pend_num_next = pend_num_reg;
    pend_den_next = pend_den_reg;
    clk_en_next   = 1'b0;
    cfg_err_next  = accept && !cfg_ok;
    case (state_reg)
      IDLE: begin
        // Covers both staying idle and the IDLE->RUN edge: a ratio taken
        // here is live from the first RUN cycle.
        acc_next = '0;
        if (take) begin
          num_next = cfg.cfg_num;
          den_next = cfg.cfg_den;
        end
      end
      RUN: begin
        if (!en) begin
          acc_next = '0;
          if (take) begin
            num_next = cfg.cfg_num;
            den_next = cfg.cfg_den;
          end
        end else begin
          clk_en_next = hit;
          acc_next    = hit ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
          if (take) begin
            pend_num_next = cfg.cfg_num;
            pend_den_next = cfg.cfg_den;
          end
        end
      end
      PEND: begin
        if (!en) begin
          acc_next = '0;
          num_next = pend_num_reg;
          den_next = pend_den_reg;
        end else begin
          clk_en_next = hit;
          if (hit || num_zero) begin
            // Swap ratio at a period boundary: phase restarts at zero so the
            // new ratio's first period is complete.
            acc_next = '0;
            num_next = pend_num_reg;
            den_next = pend_den_reg;
          end else begin
            acc_next = sum[ACC_W-1:0];
          end
        end
      end
      default: acc_next = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_reg      <= '0;
      num_reg      <= ACC_W'(DEFAULT_NUM);
      den_reg      <= ACC_W'(DEFAULT_DEN);
      pend_num_reg <= '0;
      pend_den_reg <= '0;
      clk_en_reg   <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      acc_reg      <= acc_next;
      num_reg      <= num_next;
      den_reg      <= den_next;
      pend_num_reg <= pend_num_next;
      pend_den_reg <= pend_den_next;
      clk_en_reg   <= clk_en_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  assign clk_en  = clk_en_reg;
  assign cfg_err = cfg_err_reg;

`ifdef FRAC_CLK_EN_CNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE && en) cnt_next = '0;
    else if (clk_en_next)        cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  assign pulse_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_frac_clk_en_gen.sv
module tb_frac_clk_en_gen;
  localparam int ACC_W = 16;
`ifdef FRAC_CLK_EN_CNT_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] pulse_cnt;
`endif

  logic clk_in = 1'b0;
  logic rst;
  logic en;
  logic clk_en;
  logic cfg_err;

  frac_clk_en_gen_if #(.ACC_W(ACC_W)) cfg_if ();

  frac_clk_en_gen #(
    .ACC_W(ACC_W),
    .DEFAULT_NUM(1),
    .DEFAULT_DEN(4)
`ifdef FRAC_CLK_EN_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .cfg(cfg_if),
    .clk_en(clk_en),
    .cfg_err(cfg_err)
`ifdef FRAC_CLK_EN_CNT_EN
    , .pulse_cnt(pulse_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  typedef struct {
    int num;
    int den;
    int cycles;
    int exp_pulses;
    bit same_edge;  // offer ratio on the same edge en is first sampled high
  } vec_t;

  // Ideal pulse schedule for n/d starting from phase 0: a pulse follows edge j
  // whenever floor(j*n/d) steps up.
  function automatic bit pulse_at(int j, int n, int d);
    return ((j * n) / d) != (((j - 1) * n) / d);
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Push expected clk_en for edge j of ratio n/d, advance one edge, compare.
  task automatic step_chk(string name, int n, int d, int j, output bit got);
    bit e;
    exp_q.push_back(pulse_at(j, n, d));
    tick();
    e = exp_q.pop_front();
    got = clk_en;
    check(name, clk_en, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_num = '0;
    cfg_if.cfg_den = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    bit   g;
    int   pulses;
    int   errs_seen;

    vecs[0] = '{1, 4, 40, 10, 1'b0};
    vecs[1] = '{3, 8, 80, 30, 1'b0};
    vecs[2] = '{1, 2, 20, 10, 1'b0};
    vecs[3] = '{4, 4, 12, 12, 1'b0};
    vecs[4] = '{0, 4, 12, 0,  1'b0};
    vecs[5] = '{5, 7, 14, 10, 1'b0};
    vecs[6] = '{1, 3, 30, 10, 1'b1};

    // Reset state
    do_reset();
    check("reset_clk_en", clk_en, 0);
    check("reset_cfg_err", cfg_err, 0);
    check("reset_cfg_ready", cfg_if.cfg_ready, 1);
    $display("reset: clk_en=%0d cfg_err=%0d cfg_ready=%0d", clk_en, cfg_err, cfg_if.cfg_ready);

    // Table-driven ratios, each loaded from IDLE then run
    for (int v = 0; v < 7; v++) begin
      en = 1'b0;
      check("idle_cfg_ready", cfg_if.cfg_ready, 1);
      cfg_if.cfg_num = ACC_W'(vecs[v].num);
      cfg_if.cfg_den = ACC_W'(vecs[v].den);
      cfg_if.cfg_valid = 1'b1;
      if (vecs[v].same_edge) en = 1'b1;
      tick();
      cfg_if.cfg_valid = 1'b0;
      check("cfg_err_valid_ratio", cfg_err, 0);
      if (!vecs[v].same_edge) begin
        en = 1'b1;
        tick();
      end
      check("run_edge0_clk_en", clk_en, 0);
      pulses = 0;
      for (int j = 1; j <= vecs[v].cycles; j++) begin
        step_chk("vec_clk_en", vecs[v].num, vecs[v].den, j, g);
        pulses += int'(g);
      end
      check("vec_pulse_count", pulses, vecs[v].exp_pulses);
      en = 1'b0;
      tick();
      check("idle_clk_en", clk_en, 0);
      $display("vec %0d: ratio %0d/%0d cycles=%0d pulses=%0d", v, vecs[v].num,
               vecs[v].den, vecs[v].cycles, pulses);
    end

    // Ratio change while running: pending until the next 1/4 pulse
    do_reset();
    en = 1'b1;
    tick();
    step_chk("chg_clk_en", 1, 4, 1, g);
    cfg_if.cfg_num = 16'd1;
    cfg_if.cfg_den = 16'd2;
    cfg_if.cfg_valid = 1'b1;
    step_chk("chg_clk_en", 1, 4, 2, g);
    cfg_if.cfg_valid = 1'b0;
    check("chg_ready_pend", cfg_if.cfg_ready, 0);
    step_chk("chg_clk_en", 1, 4, 3, g);
    check("chg_ready_pend", cfg_if.cfg_ready, 0);
    step_chk("chg_clk_en", 1, 4, 4, g);
    check("chg_pulse_issued", clk_en, 1);
    check("chg_ready_back", cfg_if.cfg_ready, 1);
    for (int k = 1; k <= 6; k++) step_chk("chg_new_ratio", 1, 2, k, g);
    $display("ratio change 1/4 -> 1/2 mid-period done");

    // Invalid ratios while running: error pulse, spacing stays at 4
    do_reset();
    en = 1'b1;
    tick();
    errs_seen = 0;
    for (int j = 1; j <= 16; j++) begin
      cfg_if.cfg_valid = (j == 2) || (j == 6);
      cfg_if.cfg_num = (j == 2) ? 16'd5 : 16'd1;
      cfg_if.cfg_den = (j == 2) ? 16'd3 : 16'd0;
      step_chk("inv_clk_en", 1, 4, j, g);
      check("inv_cfg_err", cfg_err, ((j == 2) || (j == 6)) ? 1 : 0);
      errs_seen += int'(cfg_err);
    end
    cfg_if.cfg_valid = 1'b0;
    check("inv_err_count", errs_seen, 2);
    $display("invalid ratios 5/3 and 1/0: cfg_err pulses=%0d", errs_seen);

    // rst mid-RUN with a pending ratio: pending discarded, back to 1/4
    do_reset();
    en = 1'b1;
    tick();
    cfg_if.cfg_num = 16'd1;
    cfg_if.cfg_den = 16'd2;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("rst_pend_ready", cfg_if.cfg_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clk_en", clk_en, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    tick();
    for (int j = 1; j <= 8; j++) step_chk("rst_default_ratio", 1, 4, j, g);
    $display("reset mid-run: ratio restored to 1/4");

`ifdef FRAC_CLK_EN_CNT_EN
    // Counter wrap with 1/1 for 2**CNT_W+3 pulses, then hold in IDLE
    do_reset();
    cfg_if.cfg_num = 16'd1;
    cfg_if.cfg_den = 16'd1;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    en = 1'b1;
    tick();
    check("cnt_clear", pulse_cnt, 0);
    repeat ((1 << CNT_W) + 3) tick();
    check("cnt_wrap", pulse_cnt, 3);
    en = 1'b0;
    repeat (4) tick();
    check("cnt_hold", pulse_cnt, 3);
    en = 1'b1;
    tick();
    check("cnt_restart", pulse_cnt, 0);
    $display("pulse counter: wrap and hold done, cnt=%0d", pulse_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
